// File: rtl/ex_stage_mc_if.sv
// Execute-stage bus: ID/EX operand side, forwarding inputs and EX/MEM result side.
// master = upstream/downstream environment, slave = the execute stage.
interface ex_stage_mc_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned NUM_FWD = 2
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                in_opcode;
  logic [DATA_W-1:0]         in_a;
  logic [DATA_W-1:0]         in_b;
  logic [DATA_W-1:0]         in_imm;
  logic                      in_alu_src;
  logic [REG_W-1:0]          in_rd;
  logic [SEL_W-1:0]          fwd_sel_a;
  logic [SEL_W-1:0]          fwd_sel_b;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_result;
  logic [REG_W-1:0]          out_rd;
  logic [2:0]                out_flags;
  logic                      busy;

  modport master (
    output in_valid, in_opcode, in_a, in_b, in_imm, in_alu_src, in_rd,
           fwd_sel_a, fwd_sel_b, fwd_data, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_flags, busy
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_imm, in_alu_src, in_rd,
           fwd_sel_a, fwd_sel_b, fwd_data, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_flags, busy
  );
endinterface

// File: rtl/ex_stage_mc.sv
// Execute stage: N-way operand forwarding, single-cycle ALU, iterative shift-add multiply,
// registered EX/MEM output with valid/ready and a persistent {Z,V,N} flag register.
// Optional: EX_SAT_ARITH_EN makes ADD/SUB saturate to the signed range on overflow.
module ex_stage_mc #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned MUL_BPC = 1
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  ex_stage_mc_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);
  localparam int unsigned SH_W  = $clog2(DATA_W);
  localparam int unsigned HALF  = DATA_W / 2;
  localparam int unsigned MUL_K = DATA_W / MUL_BPC;
  localparam int unsigned CNT_W = $clog2(MUL_K + 1);
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SMAX = ~SMIN;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4, OP_SLL = 4'd5, OP_SRA = 4'd6, OP_ROR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8, OP_LLB = 4'd9, OP_LHB = 4'd10, OP_PASS = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state, state_d;

  logic                out_valid_q;
  logic [DATA_W-1:0]   out_result_q;
  logic [REG_W-1:0]    out_rd_q;
  logic [2:0]          flags_q;
  logic [DATA_W-1:0]   mul_a, mul_b, mul_acc, mul_acc_d;
  logic [CNT_W-1:0]    mul_cnt;
  logic [REG_W-1:0]    mul_rd;
  logic                in_rdy, accept, mul_done, is_mul;
  logic [DATA_W-1:0]   opa, fwd_b, opb, sum, diff, alu_res;
  logic [2*DATA_W-1:0] rot_w;
  logic [SH_W-1:0]     sh;
  logic                ovf;
  logic [2:0]          alu_flags;

  // Operand select: an out-of-range select falls back to the register operand.
  always_comb begin
    opa   = bus.in_a;
    fwd_b = bus.in_b;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (bus.fwd_sel_a == SEL_W'(k + 1)) opa   = bus.fwd_data[k*DATA_W +: DATA_W];
      if (bus.fwd_sel_b == SEL_W'(k + 1)) fwd_b = bus.fwd_data[k*DATA_W +: DATA_W];
    end
    opb = bus.in_alu_src ? fwd_b : bus.in_imm;
  end

  always_comb begin
    sh        = opb[SH_W-1:0];
    sum       = opa + opb;
    diff      = opa - opb;
    rot_w     = {opa, opa} >> sh;
    alu_res   = '0;
    ovf       = 1'b0;
    alu_flags = flags_q;
    case (bus.in_opcode)
      OP_ADD: begin
        alu_res = sum;
        ovf     = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        ovf     = (opa[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_XOR:  alu_res = opa ^ opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_SLL:  alu_res = opa << sh;
      OP_SRA:  alu_res = DATA_W'($signed(opa) >>> sh);
      OP_ROR:  alu_res = rot_w[DATA_W-1:0];
      OP_LLB:  alu_res = {opa[DATA_W-1:HALF], opb[HALF-1:0]};
      OP_LHB:  alu_res = {opb[HALF-1:0], opa[HALF-1:0]};
      OP_PASS: alu_res = opb;
      default: alu_res = '0;
    endcase
`ifdef EX_SAT_ARITH_EN
    // Overflow direction follows the sign of A for both ADD and SUB.
    if (ovf) alu_res = opa[DATA_W-1] ? SMIN : SMAX;
`endif
    if (bus.in_opcode == OP_ADD || bus.in_opcode == OP_SUB)
      alu_flags = {alu_res == '0, ovf, alu_res[DATA_W-1]};
    else if (bus.in_opcode >= OP_XOR && bus.in_opcode <= OP_ROR)
      alu_flags = {alu_res == '0, flags_q[1:0]};
  end

  // One shift-add step retiring MUL_BPC multiplier bits.
  always_comb begin
    mul_acc_d = mul_acc;
    for (int unsigned j = 0; j < MUL_BPC; j++) begin
      if (mul_b[j]) mul_acc_d = mul_acc_d + (mul_a << j);
    end
  end

  always_comb begin
    state_d  = state;
    in_rdy   = (state == S_IDLE) && (!out_valid_q || bus.out_ready) && !flush;
    accept   = bus.in_valid && in_rdy;
    is_mul   = (bus.in_opcode == OP_MUL);
    mul_done = 1'b0;
    case (state)
      S_IDLE: if (accept && is_mul) state_d = S_MUL;
      S_MUL: begin
        if (mul_cnt == CNT_W'(MUL_K - 1)) begin
          state_d  = S_IDLE;
          mul_done = !flush;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      flags_q      <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_acc      <= '0;
      mul_cnt      <= '0;
      mul_rd       <= '0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept && !is_mul) begin
        out_valid_q  <= 1'b1;
        out_result_q <= alu_res;
        out_rd_q     <= bus.in_rd;
        flags_q      <= alu_flags;
      end else if (mul_done) begin
        out_valid_q  <= 1'b1;
        out_result_q <= mul_acc_d;
        out_rd_q     <= mul_rd;
        flags_q      <= {mul_acc_d == '0, flags_q[1:0]};
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept && is_mul) begin
        mul_a   <= opa;
        mul_b   <= opb;
        mul_acc <= '0;
        mul_cnt <= '0;
        mul_rd  <= bus.in_rd;
      end else if (state == S_MUL) begin
        mul_a   <= mul_a << MUL_BPC;
        mul_b   <= mul_b >> MUL_BPC;
        mul_acc <= mul_acc_d;
        mul_cnt <= mul_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_flags  = flags_q;
  assign bus.busy       = (state == S_MUL);
endmodule

// File: tb/tb_ex_stage_mc.sv
// Bench for ex_stage_mc: table of ALU vectors, scoreboard on output transfers,
// plus hand-written multiply latency, stall, flush and async-reset sequences.
module tb_ex_stage_mc;
  localparam int F_NONE = 0, F_Z = 1, F_ZVN = 2;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, imm;
    logic        src;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] res;
    int          fcls;
    logic        v;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  rd;
    logic [2:0]  flags;
  } exp_t;

  logic clk, rst_n, flush;
  ex_stage_mc_if #(.DATA_W(16), .REG_W(4), .NUM_FWD(2)) bus ();

  ex_stage_mc #(.DATA_W(16), .REG_W(4), .NUM_FWD(2), .MUL_BPC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  vec_t        vecs[$];
  vec_t        mvecs[$];
  logic [2:0]  mflags = 3'b000;
  logic [31:0] fwd_val = {16'h1234, 16'h00F0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] imm, input logic src, input logic [1:0] sa,
                              input logic [1:0] sbs, input logic [15:0] res, input int fcls,
                              input logic v);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.imm = imm; t.src = src; t.sel_a = sa; t.sel_b = sbs;
    t.res = res; t.fcls = fcls; t.v = v;
    return t;
  endfunction

  // Flag model: ADD/SUB write all three, logic/shift/MUL write Z, the rest keep.
  task automatic push_exp(input vec_t v, input logic [3:0] rd);
    exp_t e;
    if (v.fcls == F_ZVN)    mflags = {v.res == 16'h0, v.v, v.res[15]};
    else if (v.fcls == F_Z) mflags[2] = (v.res == 16'h0);
    e.res = v.res; e.rd = rd; e.flags = mflags;
    sb.push_back(e);
  endtask

  task automatic issue(input vec_t v, input logic [3:0] rd, input bit expect_out, output int waits);
    @(negedge clk);
    bus.in_opcode = v.op;  bus.in_a = v.a;   bus.in_b = v.b; bus.in_imm = v.imm;
    bus.in_alu_src = v.src; bus.fwd_sel_a = v.sel_a; bus.fwd_sel_b = v.sel_b;
    bus.in_rd = rd; bus.fwd_data = fwd_val; bus.in_valid = 1'b1;
    waits = 0;
    #1;
    while (!bus.in_ready && waits < 100) begin
      @(negedge clk); #1; waits++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: in_ready stayed 0 for op %0d", v.op);
    end else if (expect_out) begin
      push_exp(v, rd);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    @(negedge clk); #2;
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: compare every output transfer against the oldest expectation.
  always begin
    exp_t e;
    @(negedge clk); #1;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: result 0x%0h rd %0d", bus.out_result, bus.out_rd);
      end else begin
        e = sb.pop_front();
        check("out_result", 32'(bus.out_result), 32'(e.res));
        check("out_rd", 32'(bus.out_rd), 32'(e.rd));
        check("out_flags", 32'(bus.out_flags), 32'(e.flags));
      end
    end
  end

  initial begin
    int w, wsum, lat, busy_cnt, rdy_cnt, seen;
    logic [2:0] fl_before;
    vec_t t;

`ifdef EX_SAT_ARITH_EN
    vecs.push_back(mk(4'd0, 16'h7FFF, 16'h0000, 16'h0001, 1'b0, 2'd0, 2'd0, 16'h7FFF, F_ZVN, 1'b1));
`else
    vecs.push_back(mk(4'd0, 16'h7FFF, 16'h0000, 16'h0001, 1'b0, 2'd0, 2'd0, 16'h8000, F_ZVN, 1'b1));
`endif
    vecs.push_back(mk(4'd2, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 2'd2, 2'd0, 16'h0000, F_Z, 1'b0));
    vecs.push_back(mk(4'd2, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 2'd3, 2'd0, 16'hEDCB, F_Z, 1'b0));
    vecs.push_back(mk(4'd3, 16'h0F0F, 16'h00FF, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h000F, F_Z, 1'b0));
    vecs.push_back(mk(4'd4, 16'h0F00, 16'hAAAA, 16'h0000, 1'b1, 2'd0, 2'd1, 16'h0FF0, F_Z, 1'b0));
    vecs.push_back(mk(4'd5, 16'h0001, 16'h0013, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0008, F_Z, 1'b0));
    vecs.push_back(mk(4'd6, 16'h8000, 16'h0004, 16'h0000, 1'b1, 2'd0, 2'd0, 16'hF800, F_Z, 1'b0));
    vecs.push_back(mk(4'd7, 16'h1234, 16'h0004, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h4123, F_Z, 1'b0));
    vecs.push_back(mk(4'd7, 16'h1234, 16'h0000, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h1234, F_Z, 1'b0));
    vecs.push_back(mk(4'd9, 16'hABCD, 16'h0000, 16'h0012, 1'b0, 2'd0, 2'd0, 16'hAB12, F_NONE, 1'b0));
    vecs.push_back(mk(4'd10, 16'hABCD, 16'h0034, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h34CD, F_NONE, 1'b0));
    vecs.push_back(mk(4'd11, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 2'd0, 2'd0, 16'hBEEF, F_NONE, 1'b0));
    vecs.push_back(mk(4'd13, 16'h1111, 16'h2222, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0000, F_NONE, 1'b0));
    vecs.push_back(mk(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0000, F_ZVN, 1'b0));
`ifdef EX_SAT_ARITH_EN
    vecs.push_back(mk(4'd1, 16'h8000, 16'h0001, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h8000, F_ZVN, 1'b1));
`else
    vecs.push_back(mk(4'd1, 16'h8000, 16'h0001, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h7FFF, F_ZVN, 1'b1));
`endif
    vecs.push_back(mk(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0000, F_ZVN, 1'b0));
    vecs.push_back(mk(4'd5, 16'h8001, 16'h0010, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h8001, F_Z, 1'b0));
    vecs.push_back(mk(4'd1, 16'h0000, 16'h0001, 16'h0000, 1'b1, 2'd0, 2'd0, 16'hFFFF, F_ZVN, 1'b0));

    mvecs.push_back(mk(4'd8, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0001, F_Z, 1'b0));
    mvecs.push_back(mk(4'd8, 16'h0100, 16'h0100, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0000, F_Z, 1'b0));
    mvecs.push_back(mk(4'd8, 16'h0003, 16'h0000, 16'h0007, 1'b0, 2'd0, 2'd0, 16'h0015, F_Z, 1'b0));

    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_a = '0; bus.in_b = '0; bus.in_imm = '0;
    bus.in_alu_src = 1'b0; bus.in_rd = '0; bus.fwd_sel_a = '0; bus.fwd_sel_b = '0;
    bus.fwd_data = fwd_val; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", 32'(bus.out_result), 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_out_flags", 32'(bus.out_flags), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single-cycle ops issued back to back: none may stall.
    wsum = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i], 4'(i), 1'b1, w);
      wsum += w;
    end
    check("b2b_stall_cycles", 32'(wsum), 32'd0);
    drain();

    // Multiply latency; forward channel 0 changes after accept and must be ignored.
    fwd_val = {16'h1234, 16'h0012};
    t = mk(4'd8, 16'hDEAD, 16'h0034, 16'h0000, 1'b1, 2'd1, 2'd0, 16'h03A8, F_Z, 1'b0);
    issue(t, 4'd5, 1'b1, w);
    bus.fwd_data = 32'hFFFF_FFFF;
    fwd_val = {16'h1234, 16'h00F0};
    lat = 0; busy_cnt = 0; rdy_cnt = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.in_ready) rdy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check("mul_latency", 32'(lat), 32'd16);
    check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
    check("mul_in_ready_cycles", 32'(rdy_cnt), 32'd0);
    check("mul_busy_after", 32'(bus.busy), 32'd0);
    bus.fwd_data = fwd_val;
    for (int i = 0; i < mvecs.size(); i++) issue(mvecs[i], 4'(9 + i), 1'b1, w);
    drain();

    // Output stall: only the first op is taken while out_ready is low.
    bus.out_ready = 1'b0;
    t = mk(4'd0, 16'h0001, 16'h0002, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0003, F_ZVN, 1'b0);
    issue(t, 4'd1, 1'b1, w);
    t = mk(4'd0, 16'h0004, 16'h0005, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0009, F_ZVN, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.in_opcode = t.op; bus.in_a = t.a; bus.in_b = t.b; bus.in_alu_src = t.src;
      bus.fwd_sel_a = '0; bus.fwd_sel_b = '0; bus.in_rd = 4'd2; bus.in_valid = 1'b1;
      #1;
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_result", 32'(bus.out_result), 32'h0003);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(t, 4'd2, 1'b1, w);
    t = mk(4'd1, 16'h0009, 16'h0002, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0007, F_ZVN, 1'b0);
    issue(t, 4'd3, 1'b1, w);
    drain();

    // Flush in multiply cycle 5 together with a new op.
    fl_before = mflags;
    t = mk(4'd8, 16'h0012, 16'h0034, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h03A8, F_Z, 1'b0);
    issue(t, 4'd6, 1'b0, w);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    bus.in_opcode = 4'd0; bus.in_a = 16'h0100; bus.in_b = 16'h0001; bus.in_alu_src = 1'b1;
    bus.in_rd = 4'd7; bus.in_valid = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    check("flush_busy_before", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_flags", 32'(bus.out_flags), 32'(fl_before));
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("flush_no_output", 32'(seen), 32'd0);
    t = mk(4'd0, 16'h0100, 16'h0001, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0101, F_ZVN, 1'b0);
    issue(t, 4'd7, 1'b1, w);
    drain();

    // Asynchronous reset in the middle of a multiply.
    t = mk(4'd8, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0001, F_Z, 1'b0);
    issue(t, 4'd8, 1'b0, w);
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_result", 32'(bus.out_result), 32'd0);
    check("arst_out_rd", 32'(bus.out_rd), 32'd0);
    check("arst_out_flags", 32'(bus.out_flags), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    mflags = 3'b000;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    t = mk(4'd0, 16'h0003, 16'h0000, 16'h0004, 1'b0, 2'd0, 2'd0, 16'h0007, F_ZVN, 1'b0);
    issue(t, 4'd4, 1'b1, w);
    t = mk(4'd8, 16'h0003, 16'h0007, 16'h0000, 1'b1, 2'd0, 2'd0, 16'h0015, F_Z, 1'b0);
    issue(t, 4'd9, 1'b1, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
